// File: rtl/osd_cmd_pkg.sv
// Shared types and constants for the OSD command sequencer.
package osd_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STB_H,
    STB_L,
    FIN,
    GAP_W
  } state_t;

  localparam int OSD_MAX_LEN = 5120;

  localparam logic [7:0] CMD_DISABLE  = 8'h40;
  localparam logic [7:0] CMD_ENABLE   = 8'h41;
  localparam logic [7:0] CMD_WRITE    = 8'h20;
  localparam logic [7:0] CMD_WRITE_HR = 8'h28;

  // The OSD receiver buffer holds at most OSD_MAX_LEN payload bytes.
  function automatic logic [12:0] clamp_len(input logic [12:0] len);
    return (len > 13'(OSD_MAX_LEN)) ? 13'(OSD_MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant pointer only moves when a grant is accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       srst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_reg;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_reg ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (srst) begin
      last_reg <= 1'b1;
    end else if (accept && (gnt != 2'b00)) begin
      last_reg <= gnt[1];
    end
  end

endmodule

// File: rtl/osd_cmd_sched.sv
// Arbitrates two requesters and frames command + payload bytes onto the OSD strobe port.
module osd_cmd_sched
  import osd_cmd_pkg::*;
#(
  parameter int STROBE_HI = 1,
  parameter int STROBE_LO = 1,
  parameter int GAP       = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [7:0]  cmd0,
  input  logic [7:0]  cmd1,
  input  logic [12:0] len0,
  input  logic [12:0] len1,
  input  logic [7:0]  dat0,
  input  logic [7:0]  dat1,
  output logic [1:0]  dat_ack,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        busy,
  output logic        io_osd,
  output logic        io_strobe,
  output logic [7:0]  io_din
);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [12:0] rem_reg, rem_next;
  logic        sel_reg, sel_next;
  logic        loaded_reg, loaded_next;
  logic [7:0]  din_reg, din_next;
  logic [1:0]  gnt_reg, gnt_next;
  logic [1:0]  ack_next, done_next;
  logic [1:0]  ack_reg, done_reg;
  logic        busy_reg, osd_reg, strobe_reg;
  logic [1:0]  arb_gnt;
  logic        arb_accept;

  assign arb_accept = (state_reg == IDLE) && (req != 2'b00);

  rr_arb2 u_arb (
    .clk    (clk_sys),
    .srst   (reset),
    .req    (req),
    .accept (arb_accept),
    .gnt    (arb_gnt)
  );

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rem_next    = rem_reg;
    sel_next    = sel_reg;
    loaded_next = loaded_reg;
    din_next    = din_reg;
    gnt_next    = gnt_reg;
    ack_next    = 2'b00;
    done_next   = 2'b00;
    case (state_reg)
      IDLE: begin
        if (req != 2'b00) begin
          sel_next   = arb_gnt[1];
          din_next   = arb_gnt[1] ? cmd1 : cmd0;
          rem_next   = clamp_len(arb_gnt[1] ? len1 : len0);
          gnt_next   = arb_gnt;
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = STB_H;
        cnt_next   = 16'(STROBE_HI - 1);
      end
      STB_H: begin
        if (cnt_reg == '0) begin
          state_next = STB_L;
          cnt_next   = 16'(STROBE_LO - 1);
          // Next byte goes out at the start of the low phase so it settles before the next rise.
          if (rem_reg != '0) begin
            din_next          = sel_reg ? dat1 : dat0;
            ack_next[sel_reg] = 1'b1;
            rem_next          = rem_reg - 13'd1;
            loaded_next       = 1'b1;
          end else begin
            loaded_next = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      STB_L: begin
        if (cnt_reg == '0) begin
          if (loaded_reg) begin
            state_next = STB_H;
            cnt_next   = 16'(STROBE_HI - 1);
          end else begin
            state_next         = FIN;
            done_next[sel_reg] = 1'b1;
            gnt_next           = 2'b00;
          end
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      FIN: begin
        if (GAP <= 1) begin
          state_next = IDLE;
        end else begin
          state_next = GAP_W;
          cnt_next   = 16'(GAP - 2);
        end
      end
      GAP_W: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      rem_reg    <= '0;
      sel_reg    <= 1'b0;
      loaded_reg <= 1'b0;
      din_reg    <= '0;
      gnt_reg    <= '0;
      ack_reg    <= '0;
      done_reg   <= '0;
      busy_reg   <= 1'b0;
      osd_reg    <= 1'b0;
      strobe_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rem_reg    <= rem_next;
      sel_reg    <= sel_next;
      loaded_reg <= loaded_next;
      din_reg    <= din_next;
      gnt_reg    <= gnt_next;
      ack_reg    <= ack_next;
      done_reg   <= done_next;
      busy_reg   <= (state_next != IDLE);
      osd_reg    <= (state_next == SETUP) || (state_next == STB_H) || (state_next == STB_L);
      strobe_reg <= (state_next == STB_H);
    end
  end

  assign dat_ack   = ack_reg;
  assign gnt       = gnt_reg;
  assign done      = done_reg;
  assign busy      = busy_reg;
  assign io_osd    = osd_reg;
  assign io_strobe = strobe_reg;
  assign io_din    = din_reg;

endmodule

// File: tb/tb_osd_cmd_sched.sv
// Scoreboard bench for osd_cmd_sched: expected strobed bytes are queued as stimulus is set up.
module tb_osd_cmd_sched;

  localparam int HI  = 1;
  localparam int LO  = 1;
  localparam int GAP = 2;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [1:0]  req     = 2'b00;
  logic [7:0]  cmd0    = 8'h00;
  logic [7:0]  cmd1    = 8'h00;
  logic [12:0] len0    = 13'd0;
  logic [12:0] len1    = 13'd0;
  logic [7:0]  dat0    = 8'h00;
  logic [7:0]  dat1    = 8'h00;
  logic [1:0]  dat_ack, gnt, done;
  logic        busy, io_osd, io_strobe;
  logic [7:0]  io_din;

  osd_cmd_sched #(.STROBE_HI(HI), .STROBE_LO(LO), .GAP(GAP)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .req       (req),
    .cmd0      (cmd0),
    .cmd1      (cmd1),
    .len0      (len0),
    .len1      (len1),
    .dat0      (dat0),
    .dat1      (dat1),
    .dat_ack   (dat_ack),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .io_osd    (io_osd),
    .io_strobe (io_strobe),
    .io_din    (io_din)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int strobes, acks0, acks1, osd_hi;
  logic       strobe_prev = 1'b0;
  logic [1:0] gnt_prev = 2'b00;
  logic [7:0] seed0 = 8'h00, seed1 = 8'h00;
  int idx0 = 0, idx1 = 0;
  logic [7:0] exp_q[$];
  int         ack_cyc[$];
  int         done_cyc[$];
  logic [1:0] done_val[$];
  int         gnt_cyc[$];
  logic [1:0] gnt_val[$];

  // One cycle step: pop/compare a scoreboard byte on every strobe rise, model requester data pops.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk_sys);
    cyc++;
    if (io_strobe && !strobe_prev) begin
      strobes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_byte: got strobe with io_din=%02h, required no strobe", io_din);
      end else begin
        e = exp_q.pop_front();
        if (io_din !== e) begin
          errors++;
          $display("FAIL strobe_byte: io_din=%02h required %02h", io_din, e);
        end
      end
    end
    strobe_prev = io_strobe;
    if (io_osd) osd_hi++;
    if (dat_ack[0]) begin
      acks0++;
      ack_cyc.push_back(cyc);
      idx0++;
      dat0 = seed0 + 8'(idx0);
    end
    if (dat_ack[1]) begin
      acks1++;
      ack_cyc.push_back(cyc);
      idx1++;
      dat1 = seed1 + 8'(idx1);
    end
    if (done != 2'b00) begin
      done_cyc.push_back(cyc);
      done_val.push_back(done);
      $display("txn done=%b cycle=%0d strobes=%0d acks0=%0d acks1=%0d", done, cyc, strobes, acks0, acks1);
    end
    if (gnt != 2'b00 && gnt_prev == 2'b00) begin
      gnt_cyc.push_back(cyc);
      gnt_val.push_back(gnt);
    end
    gnt_prev = gnt;
  endtask

  task automatic clear_stats();
    strobes = 0; acks0 = 0; acks1 = 0; osd_hi = 0;
    ack_cyc.delete(); done_cyc.delete(); done_val.delete();
    gnt_cyc.delete(); gnt_val.delete();
  endtask

  task automatic wait_dones(input int n, input int budget, input string name);
    int k = 0;
    while (done_cyc.size() < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (done_cyc.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: dones=%0d required %0d", name, done_cyc.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({io_osd, io_strobe} !== 2'b00) begin errors++; $display("FAIL reset_frame: osd/strobe=%b required 00", {io_osd, io_strobe}); end
    checks++;
    if (io_din !== 8'h00) begin errors++; $display("FAIL reset_din: io_din=%02h required 00", io_din); end
    checks++;
    if ({gnt, dat_ack, done} !== 6'b0) begin errors++; $display("FAIL reset_hs: gnt/ack/done=%b required 000000", {gnt, dat_ack, done}); end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b required 0", busy); end
  endtask

  task automatic test_cmd_only();
    clear_stats();
    cmd0 = 8'h41; len0 = 13'd0;
    exp_q.push_back(8'h41);
    req = 2'b01;
    tick();
    checks++;
    if ({gnt, io_osd} !== 3'b011) begin errors++; $display("FAIL latency: gnt/osd=%b required 011", {gnt, io_osd}); end
    wait_dones(1, 50, "cmd_only");
    req = 2'b00;
    checks++;
    if (done_val.size() < 1 || done_val[0] !== 2'b01) begin errors++; $display("FAIL cmd_only_done: dones=%0d required done=01", done_val.size()); end
    checks++;
    if ({io_osd, gnt} !== 3'b000) begin errors++; $display("FAIL fin_outputs: osd/gnt=%b required 000", {io_osd, gnt}); end
    checks++;
    if (osd_hi != 3 || strobes != 1) begin errors++; $display("FAIL cmd_only_len: osd_hi=%0d strobes=%0d required 3 and 1", osd_hi, strobes); end
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy: busy=%b required 1", busy); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: busy=%b required 0", busy); end
  endtask

  task automatic test_payload();
    clear_stats();
    cmd1 = 8'h20; len1 = 13'd4; seed1 = 8'hA0; idx1 = 0; dat1 = 8'hA0;
    exp_q.push_back(8'h20);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hA0 + 8'(i));
    req = 2'b10;
    wait_dones(1, 100, "payload");
    req = 2'b00;
    checks++;
    if (done_val.size() < 1 || done_val[0] !== 2'b10) begin errors++; $display("FAIL payload_done: dones=%0d required done=10", done_val.size()); end
    checks++;
    if (osd_hi != 11 || strobes != 5) begin errors++; $display("FAIL payload_len: osd_hi=%0d strobes=%0d required 11 and 5", osd_hi, strobes); end
    checks++;
    if (acks1 != 4 || acks0 != 0) begin errors++; $display("FAIL payload_acks: acks1=%0d acks0=%0d required 4 and 0", acks1, acks0); end
    for (int i = 1; i < ack_cyc.size(); i++) begin
      checks++;
      if (ack_cyc[i] - ack_cyc[i-1] != HI + LO) begin errors++; $display("FAIL ack_spacing: %0d required %0d", ack_cyc[i] - ack_cyc[i-1], HI + LO); end
    end
    repeat (2) tick();
  endtask

  task automatic test_alternate();
    logic [1:0] want;
    clear_stats();
    cmd0 = 8'h11; len0 = 13'd1; seed0 = 8'h30; idx0 = 0; dat0 = 8'h30;
    cmd1 = 8'h22; len1 = 13'd1; seed1 = 8'h50; idx1 = 0; dat1 = 8'h50;
    for (int t = 0; t < 2; t++) begin
      exp_q.push_back(8'h11); exp_q.push_back(8'h30 + 8'(t));
      exp_q.push_back(8'h22); exp_q.push_back(8'h50 + 8'(t));
    end
    req = 2'b11;
    wait_dones(4, 200, "alternate");
    req = 2'b00;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (i >= gnt_val.size() || gnt_val[i] !== want) begin errors++; $display("FAIL rr_order: grant %0d missing or wrong, required %b", i, want); end
    end
    for (int i = 1; i < 4 && i < gnt_cyc.size() && i <= done_cyc.size(); i++) begin
      checks++;
      if (gnt_cyc[i] - done_cyc[i-1] != GAP + 1) begin errors++; $display("FAIL done_to_gnt: %0d cycles required %0d", gnt_cyc[i] - done_cyc[i-1], GAP + 1); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL alternate_bytes: %0d bytes left required 0", exp_q.size()); end
  endtask

  task automatic test_clamp();
    clear_stats();
    cmd0 = 8'h28; len0 = 13'd6000; seed0 = 8'h00; idx0 = 0; dat0 = 8'h00;
    exp_q.push_back(8'h28);
    for (int i = 0; i < 5120; i++) exp_q.push_back(8'(i));
    req = 2'b01;
    wait_dones(1, 12000, "clamp");
    req = 2'b00;
    checks++;
    if (acks0 != 5120) begin errors++; $display("FAIL clamp_acks: %0d required 5120", acks0); end
    checks++;
    if (strobes != 5121) begin errors++; $display("FAIL clamp_strobes: %0d required 5121", strobes); end
    checks++;
    if (osd_hi != 1 + 5121 * (HI + LO)) begin errors++; $display("FAIL clamp_osd: %0d required %0d", osd_hi, 1 + 5121 * (HI + LO)); end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    int k = 0;
    clear_stats();
    cmd0 = 8'h20; len0 = 13'd4; seed0 = 8'hC0; idx0 = 0; dat0 = 8'hC0;
    exp_q.push_back(8'h20);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hC0 + 8'(i));
    req = 2'b01;
    while (strobes < 3 && k < 50) begin tick(); k++; end
    checks++;
    if (strobes != 3 || io_strobe !== 1'b1) begin errors++; $display("FAIL reach_stb3: strobes=%0d strobe=%b required 3 and 1", strobes, io_strobe); end
    reset = 1'b1; req = 2'b00;
    tick();
    checks++;
    if ({io_osd, io_strobe, gnt} !== 4'b0000) begin errors++; $display("FAIL mid_reset: osd/strobe/gnt=%b required 0000", {io_osd, io_strobe, gnt}); end
    checks++;
    if ({done, dat_ack, busy} !== 5'b0) begin errors++; $display("FAIL mid_reset_hs: done/ack/busy=%b required 00000", {done, dat_ack, busy}); end
    reset = 1'b0;
    exp_q.delete();
    tick();
    checks++;
    if (done_cyc.size() != 0) begin errors++; $display("FAIL mid_reset_done: %0d done pulses required 0", done_cyc.size()); end
    // Pointer must be back at 1 so requester 0 wins the tie.
    clear_stats();
    cmd0 = 8'h41; len0 = 13'd0; cmd1 = 8'h40; len1 = 13'd0;
    exp_q.push_back(8'h41); exp_q.push_back(8'h40);
    req = 2'b11;
    tick();
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL ptr_restore: gnt=%b required 01", gnt); end
    wait_dones(1, 50, "tie_first");
    req = 2'b10;
    wait_dones(2, 50, "tie_second");
    req = 2'b00;
    checks++;
    if (done_val.size() < 2 || done_val[1] !== 2'b10) begin errors++; $display("FAIL tie_second_done: dones=%0d required second done=10", done_val.size()); end
    repeat (2) tick();
  endtask

  task automatic test_drop_req();
    clear_stats();
    cmd0 = 8'h28; len0 = 13'd3; seed0 = 8'hD0; idx0 = 0; dat0 = 8'hD0;
    cmd1 = 8'h41; len1 = 13'd0;
    exp_q.push_back(8'h28);
    for (int i = 0; i < 3; i++) exp_q.push_back(8'hD0 + 8'(i));
    exp_q.push_back(8'h41);
    req = 2'b01;
    repeat (3) tick();
    req = 2'b11;
    repeat (2) tick();
    req = 2'b10;
    wait_dones(1, 50, "drop_first");
    checks++;
    if (done_val.size() < 1 || done_val[0] !== 2'b01) begin errors++; $display("FAIL drop_done0: dones=%0d required done=01", done_val.size()); end
    checks++;
    if (acks0 != 3) begin errors++; $display("FAIL drop_acks: %0d required 3", acks0); end
    wait_dones(2, 50, "drop_second");
    req = 2'b00;
    checks++;
    if (gnt_val.size() < 2 || gnt_val[1] !== 2'b10) begin errors++; $display("FAIL drop_next_gnt: grants=%0d required second gnt=10", gnt_val.size()); end
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drop_bytes: %0d bytes left required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_cmd_only();
    test_payload();
    test_alternate();
    test_clamp();
    test_reset_mid();
    test_drop_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
